pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory stalls, and produces the EX-stage forwarding selects from the EX/MEM and MEM/WB destination fields. It also keeps a saturating stall counter and a sticky memory-timeout error.

## Interface
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before error
- CNT_W, 16: stall counter width

- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- id_rs, id_rt  in  5  source registers of instruction in ID
- ex_rs, ex_rt  in  5  source registers of instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_rt_dest  in  5  load destination in EX
- branch_taken  in  1  branch in EX resolved taken
- exmem_dest  in  5  EX/MEM forwarding destination
- exmem_regwrite  in  1  EX/MEM WB write bit
- memwb_dest  in  5  MEM/WB destination
- memwb_regwrite  in  1  MEM/WB WB write bit
- mem_req  in  1  EX/MEM M field requests a data-memory access
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en  out  1  register load enables
- ifid_flush, idex_flush  out  1  load zero (bubble) into IF/ID, ID/EX
- memwb_bubble  out  1  load zero into MEM/WB
- fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_count  out  CNT_W  saturating count of stall cycles
- mem_err  out  1  sticky memory timeout

## Operation
- States: RUN, MEM_WAIT, HALT. Control outputs are Mealy, derived from state and inputs. State, wait counter, stall_count and mem_err are registered.
- Reset (reset_n=0 at an edge): state=RUN, wait counter=0, stall_count=0, mem_err=0. While reset_n=0: all enables 0, all flush/bubble 0, fwd 00.
- RUN, priority high to low:
  - Memory stall, when mem_req && !mem_ready:
    - All four enables = 0; memwb_bubble = 1.
    - Next state MEM_WAIT, wait counter = 1.
    - No flush asserted.
  - Branch, when branch_taken:
    - All enables = 1; ifid_flush = 1, idex_flush = 1.
    - A load-use hazard in the same cycle is ignored, because the dependent instruction is flushed.
  - Load-use, when ex_memread && ex_rt_dest != 0 && (ex_rt_dest == id_rs || ex_rt_dest == id_rt):
    - pc_en = 0, ifid_en = 0; idex_en = 1, idex_flush = 1; exmem_en = 1.
  - Otherwise: all enables = 1, no flushes.
- MEM_WAIT:
  - mem_ready = 0: freeze as above and increment the wait counter. When the wait counter reaches TIMEOUT, go to HALT and set mem_err.
  - mem_ready = 1: all enables = 1, no bubble, go to RUN, clear the wait counter.
  - branch_taken is not acted on in MEM_WAIT. It is held by the frozen ID/EX register and resolved in RUN afterwards.
- HALT: permanent freeze (all enables 0, memwb_bubble 1) until reset.
- stall_count increments by 1 on every cycle with pc_en = 0 (load-use, MEM_WAIT, HALT). It saturates at 2^CNT_W-1.
- Forwarding, evaluated per operand for fwd_a (ex_rs) and fwd_b (ex_rt):
  - 10 if exmem_regwrite && exmem_dest != 0 && exmem_dest == src.
  - Else 01 if memwb_regwrite && memwb_dest != 0 && memwb_dest == src.
  - Else 00.
  - EX/MEM takes precedence over MEM/WB. Forwarding is valid in every state.

## Timing
- Control outputs settle combinationally in the same cycle as their inputs. Registered targets act on the next rising edge.
- Load-use costs exactly 1 bubble cycle. The hazard clears on the next cycle because the load has advanced.
- Memory stall of N not-ready cycles costs N freeze cycles. The release happens in the mem_ready cycle.
- TIMEOUT: after TIMEOUT consecutive not-ready cycles, mem_err is 1 from the following edge.
- mem_ready=1 with mem_req=0 is ignored in RUN.
- Reset asserted in MEM_WAIT or HALT returns to RUN at that edge.

## Structure
- Shared pipeline package holds:
  - state enum (RUN, MEM_WAIT, HALT)
  - fwd select constants FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - register-zero constant
- One natural sub-module: fwd_unit (purely combinational forwarding selects). It is instantiated inside; FSM and counters stay in the top module.

## Test plan
- Load-use: ex_memread=1, ex_rt_dest=8, id_rs=8 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_count goes 0->1; next cycle all enables are 1.
- Branch + load-use in the same cycle: branch_taken=1 -> ifid_flush=idex_flush=1, pc_en=1, stall_count unchanged.
- Memory stall: mem_req=1, mem_ready low for 3 cycles then high -> 3 freeze cycles with memwb_bubble=1, release in cycle 4, stall_count=3, state RUN.
- Timeout with TIMEOUT=4: mem_ready held 0 -> mem_err=1 after the 4th wait cycle; outputs stay frozen; reset_n=0 for one edge clears mem_err and stall_count to 0.
- Forwarding: ex_rs=5, exmem_dest=5/regwrite=1, memwb_dest=5/regwrite=1 -> fwd_a=10. With exmem_regwrite=0 -> fwd_a=01. With dest=0 -> fwd_a=00.
- Saturation with CNT_W=4: 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// FSM states, forwarding selects, register-zero and control-word presets.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO  = '0;
    localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE     = ctrl_t'(7'b0000_000);
    localparam ctrl_t CTRL_GO       = ctrl_t'(7'b1111_000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(7'b0000_001);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(7'b1111_110);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(7'b0011_010);

    // Youngest writer wins: EX/MEM is checked before MEM/WB.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] exmem_dest,
        input logic             exmem_regwrite,
        input logic [REG_W-1:0] memwb_dest,
        input logic             memwb_regwrite
    );
        if (exmem_regwrite && (exmem_dest != REG_ZERO) && (exmem_dest == src)) begin
            return FWD_EXMEM;
        end
        if (memwb_regwrite && (memwb_dest != REG_ZERO) && (memwb_dest == src)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard sources in, register
// controls, forwarding selects and status out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt_dest;
    logic             branch_taken;
    logic [REG_W-1:0] exmem_dest;
    logic             exmem_regwrite;
    logic [REG_W-1:0] memwb_dest;
    logic             memwb_regwrite;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [FWD_W-1:0] fwd_a;
    logic [FWD_W-1:0] fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic             mem_err;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_memread, ex_rt_dest, branch_taken,
               exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite,
               mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, fwd_a, fwd_b, stall_count, mem_err
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_memread, ex_rt_dest, branch_taken,
               exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite,
               mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, fwd_a, fwd_b, stall_count, mem_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] exmem_dest,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] memwb_dest,
    input  logic             memwb_regwrite,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_sel(ex_rs, exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite);
        fwd_b = fwd_sel(ex_rt, exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch-flush and data-memory stall
// handling with a saturating stall counter and sticky memory-timeout error.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clock,
    input logic               reset_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_err_q;
    logic              err_nxt;
    logic              load_use;
    ctrl_t             ctrl;
    logic [FWD_W-1:0]  fwd_a_raw;
    logic [FWD_W-1:0]  fwd_b_raw;

    pipe_hazard_ctrl_fwd_unit u_fwd (
        .ex_rs          (bus.ex_rs),
        .ex_rt          (bus.ex_rt),
        .exmem_dest     (bus.exmem_dest),
        .exmem_regwrite (bus.exmem_regwrite),
        .memwb_dest     (bus.memwb_dest),
        .memwb_regwrite (bus.memwb_regwrite),
        .fwd_a          (fwd_a_raw),
        .fwd_b          (fwd_b_raw)
    );

    assign load_use = bus.ex_memread && (bus.ex_rt_dest != REG_ZERO) &&
                      ((bus.ex_rt_dest == bus.id_rs) || (bus.ex_rt_dest == bus.id_rt));

    // Mealy control word and next-state; everything reads as idle while in reset.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_err_q;
        wait_inc  = wait_cnt + WAIT_W'(1);
        if (reset_n) begin
            unique case (state)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        ctrl     = CTRL_FREEZE;
                        wait_nxt = WAIT_W'(1);
                        if (WAIT_W'(1) >= WAIT_W'(TIMEOUT)) begin
                            state_nxt = HALT;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = MEM_WAIT;
                        end
                    end else if (bus.branch_taken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end else begin
                        ctrl = CTRL_GO;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        ctrl      = CTRL_GO;
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else begin
                        ctrl     = CTRL_FREEZE;
                        wait_nxt = wait_inc;
                        if (wait_inc >= WAIT_W'(TIMEOUT)) begin
                            state_nxt = HALT;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                HALT: begin
                    ctrl = CTRL_FREEZE;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_err_q <= err_nxt;
            if (!ctrl.pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.ifid_en      = ctrl.ifid_en;
    assign bus.idex_en      = ctrl.idex_en;
    assign bus.exmem_en     = ctrl.exmem_en;
    assign bus.ifid_flush   = ctrl.ifid_flush;
    assign bus.idex_flush   = ctrl.idex_flush;
    assign bus.memwb_bubble = ctrl.memwb_bubble;
    assign bus.fwd_a        = reset_n ? fwd_a_raw : FWD_REG;
    assign bus.fwd_b        = reset_n ? fwd_b_raw : FWD_REG;
    assign bus.stall_count  = stall_cnt;
    assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit       rst_n;
        bit [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rt_dest, exmem_dest, memwb_dest;
        bit       ex_memread, branch_taken, exmem_regwrite, memwb_regwrite;
        bit       mem_req, mem_ready;
    } stim_t;

    typedef struct packed {
        logic [6:0]       ctl;   // pc, ifid, idex, exmem, ifid_flush, idex_flush, bubble
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic             err;
    } obs_t;

    logic clock;
    logic reset_n;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model state: consecutive not-ready cycles in the current memory stall,
    // whether the core is halted, the stall tally and the error flag.
    int waiting = 0;
    bit halted  = 0;
    int stalls  = 0;
    bit err     = 0;

    function automatic bit [1:0] ref_fwd(input bit [4:0] src, input stim_t s);
        if (s.exmem_regwrite && s.exmem_dest != 0 && s.exmem_dest == src) return 2'b10;
        if (s.memwb_regwrite && s.memwb_dest != 0 && s.memwb_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        obs_t e;
        bit   lu;
        @(posedge clock);
        #1;
        reset_n            = s.rst_n;
        bus.id_rs          = s.id_rs;
        bus.id_rt          = s.id_rt;
        bus.ex_rs          = s.ex_rs;
        bus.ex_rt          = s.ex_rt;
        bus.ex_memread     = s.ex_memread;
        bus.ex_rt_dest     = s.ex_rt_dest;
        bus.branch_taken   = s.branch_taken;
        bus.exmem_dest     = s.exmem_dest;
        bus.exmem_regwrite = s.exmem_regwrite;
        bus.memwb_dest     = s.memwb_dest;
        bus.memwb_regwrite = s.memwb_regwrite;
        bus.mem_req        = s.mem_req;
        bus.mem_ready      = s.mem_ready;

        e.sc  = CNT_W'(stalls);
        e.err = err;
        e.ctl = 7'b0000_000;
        e.fa  = 2'b00;
        e.fb  = 2'b00;
        if (!s.rst_n) begin
            exp_q.push_back(e);
            waiting = 0;
            halted  = 0;
            stalls  = 0;
            err     = 0;
            return;
        end
        e.fa = ref_fwd(s.ex_rs, s);
        e.fb = ref_fwd(s.ex_rt, s);
        lu = s.ex_memread && s.ex_rt_dest != 0 &&
             (s.ex_rt_dest == s.id_rs || s.ex_rt_dest == s.id_rt);
        if (halted) begin
            e.ctl = 7'b0000_001;
        end else if (waiting > 0 || (s.mem_req && !s.mem_ready)) begin
            if (waiting > 0 && s.mem_ready) begin
                e.ctl   = 7'b1111_000;
                waiting = 0;
            end else begin
                e.ctl   = 7'b0000_001;
                waiting = waiting + 1;
                if (waiting >= TIMEOUT) begin
                    halted = 1;
                    err    = 1;
                end
            end
        end else if (s.branch_taken) begin
            e.ctl = 7'b1111_110;
        end else if (lu) begin
            e.ctl = 7'b0011_010;
        end else begin
            e.ctl = 7'b1111_000;
        end
        if (e.ctl[6] == 1'b0 && stalls < CNT_MAX) stalls = stalls + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
    always @(negedge clock) begin
        obs_t got, e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{ctl: {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                          bus.ifid_flush, bus.idex_flush, bus.memwb_bubble},
                    fa: bus.fwd_a, fb: bus.fwd_b, sc: bus.stall_count, err: bus.mem_err};
            checks = checks + 1;
            if (got !== e) begin
                errors = errors + 1;
                $display("FAIL cycle%0d ctl got=%b exp=%b fwd_a got=%b exp=%b fwd_b got=%b exp=%b stall_count got=%0d exp=%0d mem_err got=%b exp=%b",
                         cyc, got.ctl, e.ctl, got.fa, e.fa, got.fb, e.fb, got.sc, e.sc, got.err, e.err);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n          = ($urandom_range(0, 59) != 0);
        s.id_rs          = 5'($urandom_range(0, 3));
        s.id_rt          = 5'($urandom_range(0, 3));
        s.ex_rs          = 5'($urandom_range(0, 3));
        s.ex_rt          = 5'($urandom_range(0, 3));
        s.ex_rt_dest     = 5'($urandom_range(0, 3));
        s.exmem_dest     = 5'($urandom_range(0, 3));
        s.memwb_dest     = 5'($urandom_range(0, 3));
        s.ex_memread     = ($urandom_range(0, 1) == 1);
        s.branch_taken   = ($urandom_range(0, 4) == 0);
        s.exmem_regwrite = ($urandom_range(0, 9) < 7);
        s.memwb_regwrite = ($urandom_range(0, 9) < 7);
        s.mem_req        = ($urandom_range(0, 9) < 3);
        s.mem_ready      = ($urandom_range(0, 1) == 1);
        return s;
    endfunction

    initial begin
        stim_t s;
        reset_n = 1'b0;
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_rs = '0; bus.ex_rt = '0;
        bus.ex_memread = 1'b0; bus.ex_rt_dest = '0; bus.branch_taken = 1'b0;
        bus.exmem_dest = '0; bus.exmem_regwrite = 1'b0; bus.memwb_dest = '0;
        bus.memwb_regwrite = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

        s = idle(); s.rst_n = 0;
        apply(s); apply(s);
        apply(idle());

        // load-use on r8, then the load has advanced
        s = idle(); s.ex_memread = 1; s.ex_rt_dest = 8; s.id_rs = 8;
        apply(s);
        s.ex_memread = 0;
        apply(s);

        // branch overrides the same-cycle load-use
        s = idle(); s.ex_memread = 1; s.ex_rt_dest = 8; s.id_rt = 8; s.branch_taken = 1;
        apply(s);
        apply(idle());

        // three not-ready cycles then release; ready without request is ignored
        s = idle(); s.mem_req = 1;
        repeat (3) apply(s);
        s.mem_ready = 1;
        apply(s);
        s = idle(); s.mem_ready = 1;
        apply(s);

        // forwarding precedence and register zero
        s = idle(); s.ex_rs = 5; s.ex_rt = 5;
        s.exmem_dest = 5; s.exmem_regwrite = 1; s.memwb_dest = 5; s.memwb_regwrite = 1;
        apply(s);
        s.exmem_regwrite = 0;
        apply(s);
        s.ex_rs = 0; s.ex_rt = 0; s.exmem_dest = 0; s.memwb_dest = 0; s.exmem_regwrite = 1;
        apply(s);

        // timeout into halt; halt ignores mem_ready until reset
        s = idle(); s.rst_n = 0;
        apply(s);
        s = idle(); s.mem_req = 1;
        repeat (6) apply(s);
        s.mem_ready = 1; s.branch_taken = 1;
        repeat (2) apply(s);
        s = idle(); s.rst_n = 0;
        apply(s);
        apply(idle());

        // stall counter saturation
        s = idle(); s.ex_memread = 1; s.ex_rt_dest = 3; s.id_rt = 3;
        repeat (20) apply(s);
        apply(idle());

        repeat (3000) apply(rand_stim());

        @(negedge clock);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
